imm_ext_stage: RTL
==================

Name: imm_ext_stage

Overview:
Parametrised, registered immediate-extension stage between ID and EX in the dynamic pipeline. Takes an IN_W-bit immediate plus a mode and tag. Produces the OUT_W-bit extended operand one cycle later. Uses a valid/ready handshake with a 2-entry skid buffer, so EX back-pressure never drops or duplicates an operand. A synchronous flush kills in-flight entries on a branch mispredict.

Parameters:
IN_W, 16, immediate input width
OUT_W, 32, extended output width; OUT_W >= IN_W + BR_SHIFT is required
BR_SHIFT, 2, left shift applied in branch-offset mode
TAG_W, 5, width of the sideband tag (e.g. destination register) carried with each entry

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  synchronous kill of all held and incoming entries
in_valid  in  1  input entry valid
in_ready  out  1  stage can accept an input this cycle
in_imm  in  IN_W  raw immediate
in_mode  in  2  00 zero-ext, 01 sign-ext, 10 upper (load-upper), 11 branch (sign-ext then << BR_SHIFT)
in_tag  in  TAG_W  sideband tag
out_valid  out  1  output entry valid
out_ready  in  1  consumer accepts output this cycle
out_data  out  OUT_W  extended immediate
out_tag  out  TAG_W  tag of the output entry

Behaviour:
- Extension is combinational on the input side; stored entries hold the already-extended value.
  - mode 00: {zeros, imm}
  - mode 01: {IN_W-bit sign replicated, imm}
  - mode 10: {imm, (OUT_W-IN_W) zeros}
  - mode 11: sign-extend to OUT_W, shift left BR_SHIFT, keep low OUT_W bits.
- Storage:
  - Output register (out_valid/out_data/out_tag) plus one skid register (skid_valid/skid_data/skid_tag).
  - in_ready = !skid_valid; it is driven from a register, with no combinational path from out_ready.
  - in_ready is 0 while rst is high.
- Accept occurs when in_valid && in_ready. Drain occurs when out_valid && out_ready.
- Per-cycle update, with flush = 0:
  - Output register is empty or draining:
    - If skid is valid, skid moves to output, and any accepted input is written to skid.
    - Otherwise an accepted input loads output directly (latency 1 cycle) and skid stays empty.
    - With no accept, out_valid follows skid_valid.
  - Output register is full and not draining: an accepted input is written to skid.
  - Ordering is strict FIFO. No entry is lost or duplicated.
- Throughput: 1 entry/cycle when out_ready is held 1. in_ready stays 1 in that case.
- flush = 1, sampled at the clock edge:
  - out_valid and skid_valid clear to 0.
  - Any input offered that cycle is discarded.
  - Flush has priority over accept and drain.
  - in_ready is 1 the following cycle.
- out_data and out_tag are don't-care while out_valid = 0. They change only on a load.
- Reset, asynchronous, effective immediately without a clock edge:
  - out_valid = 0, out_data = 0, out_tag = 0
  - skid_valid = 0, skid_data = 0, skid_tag = 0
  - Reset asserted mid-transfer discards all entries.
  - After deassertion, in_ready = 1 (skid empty).
- Simultaneous drain + accept with skid full: skid moves to output, and no accept happens because in_ready = 0.
- in_mode takes only values 00-11. All four encodings are legal; there is no illegal-mode state.

Test Plan:
1. Defaults, out_ready = 1:
   - mode 01, imm 0x8001 -> next cycle out_valid = 1, out_data 0xFFFF8001
   - mode 00, imm 0x8001 -> 0x00008001
   - mode 10, imm 0x1234 -> 0x12340000
   - mode 11, imm 0xFFFF -> 0xFFFFFFFC
   - mode 11, imm 0x0004 -> 0x00000010
   - Tags are echoed unchanged.
2. Back-pressure:
   - out_ready = 0; offer A (tag 1), B (tag 2), C (tag 3) on consecutive cycles.
   - A is held in output, B goes to skid, in_ready falls to 0, and C stalls.
   - Then out_ready = 1 -> outputs A, B, C on consecutive cycles, no loss or duplication, in_ready returns to 1.
3. Flush:
   - Fill both entries with out_ready = 0, offer D, and assert flush for 1 cycle.
   - Next cycle out_valid = 0 and in_ready = 1.
   - None of the three entries ever appears on the output.
4. Async reset:
   - With out_valid = 1 and skid full, raise rst between clock edges.
   - out_valid, out_data and out_tag go to 0 before the next edge.
   - After release, the first new input appears 1 cycle after acceptance.
5. Streaming: in_valid every cycle for 8 entries with out_ready = 1 -> 8 back-to-back outputs in order, in_ready stays 1 throughout.
6. Random stress:
   - Randomise in_valid, out_ready, flush (low rate) and in_mode for 10k cycles against a reference queue model.
   - Check output ordering, extension values and the no-loss rule.

Source files
------------

// File: rtl/imm_ext_stage_if.sv
// imm_ext_stage_if
// Groups the two valid/ready handshakes of the immediate-extension stage.
//
// Handshake rule for both sides: a transfer happens on a rising clock
// edge where valid && ready are both 1. A producer holds valid and its
// payload stable until the transfer. A consumer may raise or lower ready
// freely.
//
// Signals:
//   in_valid / in_ready   : upstream (ID) handshake
//   in_imm [IN_W]         : raw immediate
//   in_mode [2]           : 00 zero, 01 sign, 10 upper, 11 branch offset
//   in_tag [TAG_W]        : sideband tag travelling with the entry
//   out_valid / out_ready : downstream (EX) handshake
//   out_data [OUT_W]      : extended immediate
//   out_tag [TAG_W]       : tag of the output entry
//
// Modports:
//   slave  : the stage itself
//   master : the surrounding pipeline / testbench
interface imm_ext_stage_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_imm, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

    modport master (
        output in_valid, in_imm, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );
endinterface

// File: rtl/imm_ext_stage.sv
// imm_ext_stage
// Registered immediate-extension stage between ID and EX. The immediate is
// extended combinationally on entry; the output register and a single skid
// register hold already-extended values, giving a 2-entry FIFO whose
// in_ready comes only from state (no path from out_ready).
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst   : asynchronous active-high reset, clears both entries
//   flush : synchronous kill of held entries and of the offered input
//   bus   : imm_ext_stage_if.slave (in_* and out_* handshakes)
module imm_ext_stage #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 32,
    parameter int BR_SHIFT = 2,
    parameter int TAG_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    imm_ext_stage_if.slave  bus
);

    if (OUT_W < IN_W + BR_SHIFT) begin : g_width_check
        $error("imm_ext_stage: OUT_W must be >= IN_W + BR_SHIFT");
    end

    localparam int PAD = OUT_W - IN_W;

    logic             out_valid_q;
    logic [OUT_W-1:0] out_data_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             skid_valid_q;
    logic [OUT_W-1:0] skid_data_q;
    logic [TAG_W-1:0] skid_tag_q;

    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] ext_data;
    logic             accept;
    logic             out_free;

    assign zext = OUT_W'(bus.in_imm);
    assign sext = OUT_W'($signed(bus.in_imm));

    always_comb begin
        ext_data = zext;
        unique case (bus.in_mode)
            2'b00: ext_data = zext;
            2'b01: ext_data = sext;
            2'b10: ext_data = zext << PAD;
            2'b11: ext_data = sext << BR_SHIFT;
        endcase
    end

    // Ready is a pure function of the skid flag; held low while in reset.
    assign bus.in_ready = !skid_valid_q && !rst;
    assign accept       = bus.in_valid && bus.in_ready;
    // Output slot can take a new entry this cycle (empty or being drained).
    assign out_free     = !out_valid_q || bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_tag_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_tag_q   <= '0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                // Oldest entry sits in skid; it moves forward first. An
                // accept cannot coincide here because in_ready is low, but
                // the write is kept so the FIFO rule stays explicit.
                out_valid_q  <= 1'b1;
                out_data_q   <= skid_data_q;
                out_tag_q    <= skid_tag_q;
                skid_valid_q <= accept;
                if (accept) begin
                    skid_data_q <= ext_data;
                    skid_tag_q  <= bus.in_tag;
                end
            end else if (accept) begin
                out_valid_q <= 1'b1;
                out_data_q  <= ext_data;
                out_tag_q   <= bus.in_tag;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            // Output stalled: park the new entry in skid.
            skid_valid_q <= 1'b1;
            skid_data_q  <= ext_data;
            skid_tag_q   <= bus.in_tag;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_tag   = out_tag_q;

endmodule
